// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and width helper for the serial transmitter
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Ceiling log2, used to size the bit counter (WIDTH >= 2 gives at least 1 bit)
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - bit position counter with load-zero, increment and terminal count
module piso_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          load_zero,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    // Load-zero has priority so a reload on the last bit restarts the word cleanly
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt <= '0;
        end else if (load_zero) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with frame and done strobes
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             accept;
    logic             cnt_inc;
    logic             out_bit;

    // Ready depends on state only, so an upstream source can never form a loop through it
    assign load_ready = (state == ST_IDLE) | ((state == ST_SHIFT) & tc);
    assign accept     = load_valid & load_ready;
    assign cnt_inc    = (state == ST_SHIFT) & ~tc;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk       (clk),
        .clear_n   (reset),
        .load_zero (accept),
        .inc       (cnt_inc),
        .cnt       (cnt),
        .tc        (tc)
    );

    // Shift toward the output end with zero fill; direction chosen by MSB_FIRST
    always_comb begin
        sr_shifted = '0;
        if (MSB_FIRST) begin
            sr_shifted = {sr[WIDTH-2:0], 1'b0};
        end else begin
            sr_shifted = {1'b0, sr[WIDTH-1:1]};
        end
    end

    // FSM and shift register; a reload on the last bit keeps SHIFT for gapless words
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            sr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sr    <= load_data;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (accept) begin
                        sr <= load_data;
                    end else if (tc) begin
                        sr    <= '0;
                        state <= ST_IDLE;
                    end else begin
                        sr <= sr_shifted;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sr    <= '0;
                end
            endcase
        end
    end

    // Output decode from registered state only; ser_out is forced low outside SHIFT
    assign out_bit     = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign ser_valid   = (state == ST_SHIFT);
    assign ser_out     = ser_valid & out_bit;
    assign frame_start = ser_valid & (cnt == '0);
    assign done        = ser_valid & tc;

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx
module tb_piso_tx;

    logic       clk;
    logic       rst_n;

    logic       lv0, lr0, so0, sv0, fs0, dn0;
    logic [3:0] ld0;
    logic       lv1, lr1, so1, sv1, fs1, dn1;
    logic [3:0] ld1;
    logic [3:0] q;

    int checks;
    int errors;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .load_valid  (lv0),
        .load_ready  (lr0),
        .load_data   (ld0),
        .ser_out     (so0),
        .ser_valid   (sv0),
        .frame_start (fs0),
        .done        (dn0)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .reset       (rst_n),
        .load_valid  (lv1),
        .load_ready  (lr1),
        .load_data   (ld1),
        .ser_out     (so1),
        .ser_valid   (sv1),
        .frame_start (fs1),
        .done        (dn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial-in receiver for loopback, MSB arrives first
    always @(posedge clk) q <= {q[2:0], so0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated word on the MSB-first instance, checked bit by bit, then loopback
    task automatic send_one(input logic [3:0] d);
        lv0 = 1'b1;
        ld0 = d;
        tick();
        lv0 = 1'b0;
        ld0 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w%h_bit%0d", d, i), so0, d[3-i]);
            check($sformatf("w%h_vld%0d", d, i), sv0, 1'b1);
            check($sformatf("w%h_fs%0d", d, i), fs0, (i == 0));
            check($sformatf("w%h_done%0d", d, i), dn0, (i == 3));
            check($sformatf("w%h_rdy%0d", d, i), lr0, (i == 3));
            tick();
        end
        check($sformatf("w%h_idle_vld", d), sv0, 1'b0);
        check($sformatf("w%h_idle_out", d), so0, 1'b0);
        check($sformatf("w%h_loopback", d), q, d);
    endtask

    initial begin
        logic [7:0] b2b;
        logic [3:0] lsb_word;
        int vcount;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        lv0 = 1'b0; ld0 = 4'h0;
        lv1 = 1'b0; ld1 = 4'h0;

        // Reset held two clocks
        tick();
        tick();
        check("rst_out", so0, 1'b0);
        check("rst_vld", sv0, 1'b0);
        check("rst_fs", fs0, 1'b0);
        check("rst_done", dn0, 1'b0);
        check("rst_rdy", lr0, 1'b1);
        check("rst_rdy_lsb", lr1, 1'b1);
        rst_n = 1'b1;
        tick();
        check("post_rst_vld", sv0, 1'b0);
        check("post_rst_rdy", lr0, 1'b1);

        send_one(4'b1011);
        send_one(4'b0110);

        // Back-to-back 0xA then 0x5 with load_valid held high
        b2b    = 8'b1010_0101;
        vcount = 0;
        lv0 = 1'b1;
        ld0 = 4'hA;
        tick();
        ld0 = 4'h5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_bit%0d", i), so0, b2b[7-i]);
            check($sformatf("b2b_rdy%0d", i), lr0, ((i % 4) == 3));
            if (sv0) vcount++;
            tick();
            if (i == 3) begin
                lv0 = 1'b0;
                ld0 = 4'h0;
            end
        end
        check("b2b_valid_cycles", vcount, 8);
        check("b2b_end_vld", sv0, 1'b0);

        // LSB-first instance with an ignored mid-word load attempt
        lsb_word = 4'b0001;
        lv1 = 1'b1;
        ld1 = lsb_word;
        tick();
        lv1 = 1'b0;
        ld1 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lsb_bit%0d", i), so1, lsb_word[i]);
            check($sformatf("lsb_vld%0d", i), sv1, 1'b1);
            lv1 = (i == 1);
            ld1 = (i == 1) ? 4'hF : 4'h0;
            tick();
        end
        lv1 = 1'b0;
        check("lsb_end_vld", sv1, 1'b0);
        tick();
        check("lsb_still_idle", sv1, 1'b0);

        // Reset asserted during the second bit of 0xF
        lv0 = 1'b1;
        ld0 = 4'hF;
        tick();
        lv0 = 1'b0;
        ld0 = 4'h0;
        check("abort_bit0", so0, 1'b1);
        tick();
        check("abort_bit1", so0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_out", so0, 1'b0);
        check("abort_vld", sv0, 1'b0);
        check("abort_fs", fs0, 1'b0);
        check("abort_done", dn0, 1'b0);
        check("abort_rdy", lr0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        check("after_abort_vld", sv0, 1'b0);
        check("after_abort_out", so0, 1'b0);
        check("after_abort_rdy", lr0, 1'b1);
        tick();
        tick();
        check("after_abort_quiet", sv0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
